prio_encoder_hs: RTL and testbench
==================================

Name: prio_encoder_hs

Overview:
- Parametrised, registered priority encoder for N request lines.
- Selectable runtime mode: fixed priority (MSB wins) or round-robin priority.
- Latches the winning index and presents it on a valid/ready output handshake. Output stays stable until the consumer accepts it.
- Successor to the 4-bit combinational encoder. Used wherever a request vector is turned into one serviced index per transaction.

Parameters:
- N, 8, number of request lines; legal range 2..64; elaboration error outside this range.
- W, $clog2(N), index width; localparam derived from N, not overridable.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request vector; bit i set = requester i pending; sampled every cycle, not latched by this block.
- mode_rr  input  1  0 = fixed priority, 1 = round-robin; sampled only when a winner is computed.
- out_valid  output  1  a latched winner is presented.
- out_ready  input  1  consumer accepts the winner; handshake = out_valid && out_ready.
- out_idx  output  W  index of the latched winner.
- out_onehot  output  N  one-hot of out_idx; all-zero when out_valid = 0.
- rr_ptr  output  W  current round-robin top-priority index; debug/observability.

Behaviour:
- Reset (async assert, sync release): state = IDLE, out_valid = 0, out_idx = 0, out_onehot = 0, rr_ptr = N-1.
- Pick function, fixed mode: highest set index of req wins (N-1 first, then downward). Same ordering as the 4-bit encoder.
- Pick function, round-robin mode: search starts at rr_ptr, then rr_ptr-1, and so on downward, wrapping from 0 to N-1. First set bit wins.
- Index 0 is a real requester. An empty req never produces a grant.
- FSM states: IDLE, HOLD.
- IDLE: if req != 0, register the pick into out_idx/out_onehot, set out_valid = 1, go to HOLD. Latency is 1 cycle from req to out_valid. If req == 0, stay in IDLE.
- HOLD: out_idx, out_onehot and out_valid are held stable while out_ready = 0. Deassertion or change of req during HOLD has no effect on the outputs.
- HOLD with handshake, round-robin mode: rr_ptr <= (out_idx == 0) ? N-1 : out_idx-1, so the accepted requester drops to lowest priority.
- HOLD with handshake, fixed mode: rr_ptr is unchanged.
- HOLD with handshake, back-to-back: in the same cycle, if req != 0, register a new pick and stay in HOLD. This pick uses the updated rr_ptr value (next-state pointer, combinationally forwarded) and the current mode_rr. Throughput is one grant per cycle when out_ready is held high.
- HOLD with handshake and req == 0: out_valid <= 0, out_onehot <= 0, out_idx retains its last value, go to IDLE.
- Mode change: takes effect at the next pick only. A held winner is never re-evaluated. rr_ptr is not reset on a mode change.
- A requester that drops its bit after being latched is still presented. Withdrawal is the consumer's concern.
- Reset asserted mid-HOLD: outputs go to reset values immediately (asynchronously). The pending winner is discarded.
- Invariant (assertion in RTL): out_valid |-> out_onehot == (1 << out_idx).
- Invariant (assertion in RTL): !out_valid |-> out_onehot == 0.

Decomposition:
- Package prio_pkg holds:
  - typedef enum logic {IDLE, HOLD} prio_state_t
  - localparam-free helper function wrap_dec(idx, N) for the pointer decrement
- Sub-module prio_pick: purely combinational, parametrised by N.
  - Inputs: req, start index, mode.
  - Outputs: found, idx, onehot.
  - Implementation: double-width rotate-and-priority-search.
  - Instantiated once, fed with the next-state rr_ptr.

Test Plan:
- Fixed mode, N=8: req=8'b0101_0010, out_ready=1 -> out_valid rises 1 cycle later with out_idx=6, out_onehot=8'h40. The next cycle gives out_idx=6 again because req is unchanged. rr_ptr stays 7.
- Round-robin, N=8: req=8'hFF held, out_ready=1 from reset -> out_idx sequence 7,6,5,4,3,2,1,0,7, one grant per cycle.
- Backpressure: winner idx=3 latched, out_ready=0 for 5 cycles while req changes to 8'h80 -> out_idx stays 3 and out_valid stays 1 throughout. On out_ready=1, the next winner is 7.
- Empty and single-requester cases: req=0 -> out_valid never asserts. req=8'h01 -> out_idx=0, out_onehot=8'h01, valid after 1 cycle.
- Round-robin wrap and fairness: rr_ptr=0 after granting 1, req=8'b1000_0011 -> grants in order 0, 7, 1.
- Reset mid-HOLD: assert rst while out_valid=1, out_idx=5 -> out_valid=0, out_onehot=0, rr_ptr=7 immediately, without waiting for a clk edge. After release with req=8'h20, the first grant is idx=5.

Source files
------------

// File: rtl/prio_pkg.sv
// Shared types and helpers for the handshaked priority encoder.
package prio_pkg;

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} prio_state_t;

   // Round-robin pointer step: move one position down, wrapping from 0 to n-1.
   function automatic int unsigned wrap_dec(input int unsigned idx, input int unsigned n);
      return (idx == 0) ? n - 1 : idx - 1;
   endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational pick: finds the first set request searching downward from a start index.
module prio_pick
   import prio_pkg::*;
#(
   parameter int unsigned N = 8,
   localparam int unsigned W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   input  logic         mode_rr,
   output logic         found,
   output logic [W-1:0] idx,
   output logic [N-1:0] onehot
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   int unsigned    top;
   int unsigned    jsel;
   int unsigned    sum;

   // Rotate so the start index lands on the MSB, then a plain MSB-first search applies.
   // Fixed priority is simply a search that always starts at N-1.
   always_comb begin
      top   = mode_rr ? 32'(start) : N - 1;
      dbl   = {req, req};
      rot   = N'(dbl >> (top + 1));
      found = |req;
      jsel  = 0;
      for (int unsigned j = 0; j < N; j++) begin
         if (rot[j]) jsel = j;
      end
      sum = top + 1 + jsel;
      if (sum >= N) sum = sum - N;
      idx    = W'(sum);
      onehot = found ? (N'(1) << idx) : '0;
   end

endmodule

// File: rtl/prio_encoder_hs.sv
// Registered priority encoder (fixed or round-robin) presenting one winner per valid/ready transfer.
module prio_encoder_hs
   import prio_pkg::*;
#(
   parameter int unsigned N = 8,
   localparam int unsigned W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         mode_rr,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic [N-1:0] out_onehot,
   output logic [W-1:0] rr_ptr
);

   if (N < 2 || N > 64) begin : g_n_range
      $error("prio_encoder_hs: N=%0d outside legal range 2..64", N);
   end

   prio_state_t  state;
   prio_state_t  state_nxt;
   logic         hs;
   logic [W-1:0] ptr_nxt;
   logic         pick_found;
   logic [W-1:0] pick_idx;
   logic [N-1:0] pick_onehot;
   logic         valid_d;
   logic [W-1:0] idx_d;
   logic [N-1:0] onehot_d;

   assign hs = out_valid && out_ready;

   // Accepted requester drops to lowest priority; forwarded so a back-to-back pick sees it.
   always_comb begin
      ptr_nxt = rr_ptr;
      if (state == HOLD && hs && mode_rr) ptr_nxt = W'(wrap_dec(32'(out_idx), N));
   end

   prio_pick #(.N(N)) u_pick (
      .req     (req),
      .start   (ptr_nxt),
      .mode_rr (mode_rr),
      .found   (pick_found),
      .idx     (pick_idx),
      .onehot  (pick_onehot)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         out_valid  <= 1'b0;
         out_idx    <= '0;
         out_onehot <= '0;
         rr_ptr     <= W'(N - 1);
      end else begin
         state      <= state_nxt;
         out_valid  <= valid_d;
         out_idx    <= idx_d;
         out_onehot <= onehot_d;
         rr_ptr     <= ptr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_found) state_nxt = HOLD;
         HOLD:    if (hs && !pick_found) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A held winner is never re-evaluated; new picks load only from IDLE or on a transfer.
   always_comb begin
      valid_d  = out_valid;
      idx_d    = out_idx;
      onehot_d = out_onehot;
      case (state)
         IDLE: begin
            if (pick_found) begin
               valid_d  = 1'b1;
               idx_d    = pick_idx;
               onehot_d = pick_onehot;
            end
         end
         HOLD: begin
            if (hs) begin
               if (pick_found) begin
                  valid_d  = 1'b1;
                  idx_d    = pick_idx;
                  onehot_d = pick_onehot;
               end else begin
                  valid_d  = 1'b0;
                  onehot_d = '0;
               end
            end
         end
         default: begin
            valid_d  = 1'b0;
            onehot_d = '0;
         end
      endcase
   end

   a_onehot_valid: assert property (@(posedge clk) disable iff (rst)
      out_valid |-> (out_onehot == (N'(1) << out_idx)));

   a_onehot_idle: assert property (@(posedge clk) disable iff (rst)
      !out_valid |-> (out_onehot == '0));

endmodule

// File: tb/tb_prio_encoder_hs.sv
// Scoreboard bench for prio_encoder_hs (N=8): directed vectors, monitor compares every transfer.
module tb_prio_encoder_hs;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       mode_rr;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_idx;
   logic [7:0] out_onehot;
   logic [2:0] rr_ptr;

   typedef struct packed {
      logic [2:0] idx;
      logic [7:0] onehot;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   prio_encoder_hs #(.N(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .mode_rr    (mode_rr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_idx    (out_idx),
      .out_onehot (out_onehot),
      .rr_ptr     (rr_ptr)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] i, input logic [7:0] oh);
      exp_t e;
      e.idx    = i;
      e.onehot = oh;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   // Monitor: every accepted transfer must match the oldest expected grant.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant: got idx %0d with no grant expected at %0t", out_idx, $time);
         end else begin
            e = sb.pop_front();
            check("grant_idx", 64'(out_idx), 64'(e.idx));
            check("grant_onehot", 64'(out_onehot), 64'(e.onehot));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      req       = '0;
      mode_rr   = 1'b0;
      out_ready = 1'b0;
      #1;
      check("reset_valid", 64'(out_valid), 64'd0);
      check("reset_onehot", 64'(out_onehot), 64'd0);
      check("reset_idx", 64'(out_idx), 64'd0);
      check("reset_rr_ptr", 64'(rr_ptr), 64'd7);
      do_reset();

      // Fixed priority: MSB wins, two grants of 6, pointer untouched.
      push(3'd6, 8'h40);
      push(3'd6, 8'h40);
      req       = 8'b0101_0010;
      out_ready = 1'b1;
      check("fixed_latency_pre", 64'(out_valid), 64'd0);
      tick();
      check("fixed_latency_post", 64'(out_valid), 64'd1);
      tick();
      req = '0;
      tick();
      check("fixed_idle_valid", 64'(out_valid), 64'd0);
      check("fixed_rr_ptr", 64'(rr_ptr), 64'd7);

      // Round-robin with all requesters: 7 down to 0, then wrap to 7.
      do_reset();
      mode_rr = 1'b1;
      for (int i = 0; i < 9; i++) begin
         push(3'(7 - (i % 8)), 8'h80 >> (i % 8));
      end
      req       = 8'hFF;
      out_ready = 1'b1;
      repeat (9) tick();
      req = '0;
      tick();
      check("rr_seq_idle", 64'(out_valid), 64'd0);
      check("rr_seq_ptr", 64'(rr_ptr), 64'd6);

      // Backpressure: winner 3 held while req changes, then 7 follows.
      mode_rr   = 1'b0;
      out_ready = 1'b0;
      req       = 8'h08;
      tick();
      req = 8'h80;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_valid", 64'(out_valid), 64'd1);
         check("bp_idx", 64'(out_idx), 64'd3);
         check("bp_onehot", 64'(out_onehot), 64'h08);
      end
      push(3'd3, 8'h08);
      push(3'd7, 8'h80);
      out_ready = 1'b1;
      tick();
      req = '0;
      tick();
      check("bp_idle", 64'(out_valid), 64'd0);

      // Empty request never grants; lone requester 0 is a real grant.
      req       = '0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("empty_valid", 64'(out_valid), 64'd0);
      end
      push(3'd0, 8'h01);
      req = 8'h01;
      tick();
      check("single_valid", 64'(out_valid), 64'd1);
      req = '0;
      tick();
      check("single_idle", 64'(out_valid), 64'd0);

      // Round-robin wrap: grant 1 leaves pointer at 0, then 0, 7, 1.
      do_reset();
      mode_rr   = 1'b1;
      out_ready = 1'b0;
      req       = 8'h02;
      tick();
      push(3'd1, 8'h02);
      push(3'd0, 8'h01);
      push(3'd7, 8'h80);
      push(3'd1, 8'h02);
      req       = 8'b1000_0011;
      out_ready = 1'b1;
      tick();
      check("wrap_ptr_after_1", 64'(rr_ptr), 64'd0);
      tick();
      check("wrap_ptr_after_0", 64'(rr_ptr), 64'd7);
      tick();
      req = '0;
      tick();
      check("wrap_ptr_end", 64'(rr_ptr), 64'd0);
      check("wrap_idle", 64'(out_valid), 64'd0);

      // Reset mid-HOLD clears outputs without a clock edge.
      out_ready = 1'b0;
      req       = 8'h20;
      tick();
      check("mid_hold_valid", 64'(out_valid), 64'd1);
      check("mid_hold_idx", 64'(out_idx), 64'd5);
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid", 64'(out_valid), 64'd0);
      check("async_rst_onehot", 64'(out_onehot), 64'd0);
      check("async_rst_ptr", 64'(rr_ptr), 64'd7);
      tick();
      rst = 1'b0;
      push(3'd5, 8'h20);
      out_ready = 1'b1;
      tick();
      check("post_rst_idx", 64'(out_idx), 64'd5);
      req = '0;
      tick();
      check("post_rst_idle", 64'(out_valid), 64'd0);

      repeat (3) tick();
      check("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
